// File: rtl/rr_arbiter_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Optional lock feature is enabled with macro RR_ARBITER_LOCK_EN.
package rr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // Increment an index modulo the number of requesters.
  function automatic int wrap_inc(input int idx, input int width);
    return (idx + 1 >= width) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational circular priority search: first set req bit at or after ptr,
// wrapping from WIDTH-1 back to 0.
module rr_pick #(
  parameter int SIZE  = 3,
  parameter int WIDTH = 1 << SIZE
) (
  input  logic [WIDTH-1:0] req,
  input  logic [SIZE-1:0]  ptr,
  output logic [SIZE-1:0]  idx,
  output logic             any
);

  int k;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    idx = '0;
    any = 1'b0;
    k   = 0;
    // Walk offsets from farthest to nearest so the nearest set bit wins last.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      if (k >= WIDTH) k = k - WIDTH;
      if (req[k]) begin
        idx = SIZE'(k);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with a registered valid/ready index offer.
// Define RR_ARBITER_LOCK_EN to add the lock input that pins the pointer on handshake.
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter int SIZE  = 3,
  parameter int WIDTH = 1 << SIZE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req,
  input  logic             out_ready,
`ifdef RR_ARBITER_LOCK_EN
  input  logic             lock,
`endif
  output logic             out_valid,
  output logic [SIZE-1:0]  out_idx
);

  state_e          state_q, state_d;
  logic [SIZE-1:0] ptr_q, ptr_d;
  logic [SIZE-1:0] out_idx_q, out_idx_d;

  logic            hs;
  logic            hold;
  logic [SIZE-1:0] inc_ptr;
  logic [SIZE-1:0] pick_ptr;
  logic [SIZE-1:0] pick_idx;
  logic            pick_any;
  logic [SIZE-1:0] pick_sel;

  always_comb begin
    hs      = (state_q == OFFER) && out_ready;
    inc_ptr = SIZE'(wrap_inc(int'(out_idx_q), WIDTH));
`ifdef RR_ARBITER_LOCK_EN
    hold    = hs && lock;
`else
    hold    = 1'b0;
`endif
    // A handshake moves the search start past the granted index unless locked.
    pick_ptr = (hs && !hold) ? inc_ptr : ptr_q;
  end

  rr_pick #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    // A locked handshake re-grants the same requester if it is still asking.
    pick_sel  = (hold && req[out_idx_q]) ? out_idx_q : pick_idx;
    state_d   = state_q;
    ptr_d     = ptr_q;
    out_idx_d = out_idx_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d   = OFFER;
          out_idx_d = pick_sel;
        end
      end
      OFFER: begin
        if (hs) begin
          ptr_d = pick_ptr;
          if (pick_any) begin
            out_idx_d = pick_sel;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      out_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      out_idx_q <= out_idx_d;
    end
  end

  assign out_valid = (state_q == OFFER);
  assign out_idx   = out_idx_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (SIZE=2, WIDTH=4): vector table plus
// hand-written corner sequences, compared through an expected-output queue.
module tb_rr_arbiter;

  localparam int SIZE  = 2;
  localparam int WIDTH = 4;

  typedef struct {
    logic             rst;
    logic [WIDTH-1:0] req;
    logic             rdy;
    logic             lck;
    logic             exp_v;
    logic [SIZE-1:0]  exp_i;
  } vec_t;

  typedef struct {
    logic            v;
    logic [SIZE-1:0] i;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] req;
  logic             out_ready;
  logic             lock;
  logic             out_valid;
  logic [SIZE-1:0]  out_idx;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  always #5 clk = ~clk;

  rr_arbiter #(
    .SIZE  (SIZE),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .out_ready (out_ready),
`ifdef RR_ARBITER_LOCK_EN
    .lock      (lock),
`endif
    .out_valid (out_valid),
    .out_idx   (out_idx)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then compare.
  task automatic step(input logic r, input logic [WIDTH-1:0] q, input logic rd,
                      input logic lk, input logic ev, input logic [SIZE-1:0] ei,
                      input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; req = q; out_ready = rd; lock = lk;
    e.v = ev; e.i = ei;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({tag, ".valid"}, int'(out_valid), int'(e.v));
    if (e.v || ev === 1'b0) check({tag, ".idx"}, int'(out_idx), int'(e.i));
  endtask

  function automatic vec_t mk(input logic r, input logic [WIDTH-1:0] q, input logic rd,
                              input logic lk, input logic ev, input logic [SIZE-1:0] ei);
    vec_t v;
    v.rst = r; v.req = q; v.rdy = rd; v.lck = lk; v.exp_v = ev; v.exp_i = ei;
    return v;
  endfunction

  initial begin
    int waited;
    rst = 1'b1; req = '0; out_ready = 1'b0; lock = 1'b0;

    // reset, then idle with no requests
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 0));
    // all requesting, always ready: 0,1,2,3,0
    vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 1));
    vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 2));
    vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 3));
    vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 0));
    // offer held under backpressure, request dropped mid-offer
    vecs.push_back(mk(0, 4'b0100, 0, 0, 1, 2));
    vecs.push_back(mk(0, 4'b0100, 0, 0, 1, 2));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 2));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 2));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 1, 2));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 2));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 2));
    // wrap: ptr=3, req=0101 -> 0 then 2
    vecs.push_back(mk(0, 4'b0101, 1, 0, 1, 0));
    vecs.push_back(mk(0, 4'b0101, 1, 0, 1, 2));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 2));
    // reset during offer with ready high clears pointer
    vecs.push_back(mk(0, 4'b0010, 0, 0, 1, 1));
    vecs.push_back(mk(1, 4'b1111, 1, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 0));
    vecs.push_back(mk(0, 4'b1111, 1, 0, 1, 1));
    // sole requester is re-granted; then rotation continues past it
    vecs.push_back(mk(0, 4'b0010, 1, 0, 1, 1));
    vecs.push_back(mk(0, 4'b1010, 1, 0, 1, 3));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 3));
    vecs.push_back(mk(0, 4'b0000, 0, 0, 0, 3));
`ifdef RR_ARBITER_LOCK_EN
    vecs.push_back(mk(1, 4'b0000, 0, 0, 0, 0));
    vecs.push_back(mk(0, 4'b1010, 1, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1010, 1, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1010, 1, 1, 1, 1));
    vecs.push_back(mk(0, 4'b1010, 1, 0, 1, 3));
    vecs.push_back(mk(0, 4'b0000, 1, 0, 0, 3));
`endif

    foreach (vecs[n])
      step(vecs[n].rst, vecs[n].req, vecs[n].rdy, vecs[n].lck,
           vecs[n].exp_v, vecs[n].exp_i, $sformatf("vec%0d", n));

    // Offer must stay frozen while req churns under backpressure.
    step(1, 4'b0000, 0, 0, 0, 0, "rst2");
    step(0, 4'b0010, 0, 0, 1, 1, "hold0");
    for (int c = 0; c < 8; c++)
      step(0, WIDTH'($urandom_range(0, 15)), 0, 0, 1, 1, $sformatf("hold%0d", c + 1));
    step(0, 4'b0000, 1, 0, 0, 1, "hold_rel");

    // Bounded wait for a fresh offer from the highest requester.
    @(negedge clk);
    req = 4'b1000; out_ready = 1'b0;
    waited = 0;
    while (out_valid !== 1'b1 && waited < 4) begin
      @(negedge clk);
      waited++;
    end
    check("wait_valid", int'(out_valid), 1);
    check("wait_idx", int'(out_idx), 3);
    check("wait_latency", waited, 1);

    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
